nibble_update_sched: RTL and testbench

- Time-multiplexes one shared 4-bit add/subtract unit across the four nibbles of a 16-bit display number.
- Four pushbutton requesters ask for +STEP or -STEP on their own nibble. A round-robin scheduler grants one request at a time and sequences the shared unit.
- The granted result is written back to the nibble register.
- Sits between the raw buttons/switches and the 7-segment display driver. Replaces four per-nibble adders with one.

---
 rtl/nibble_update_sched_pkg.sv | 32 +++
 rtl/nibble_update_sched_btn_edge_sync.sv | 28 ++
 rtl/nibble_update_sched.sv | 128 ++++++++++++
 tb/tb_nibble_update_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nibble_update_sched_pkg.sv
// Shared types and helpers for the nibble update scheduler.
package nibble_update_sched_pkg;

  localparam int NNIB = 4;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // First set bit of req searching upward from ptr, wrapping mod 4.
  // Only meaningful when req is non-zero; returns ptr otherwise.
  function automatic logic [1:0] rr_pick(input logic [NNIB-1:0] req,
                                         input logic [1:0]      ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NNIB; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/nibble_update_sched_btn_edge_sync.sv
// Single-bit synchronizer followed by a one-cycle rising-edge pulse.
// SYNC_STAGES must be at least 2.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw input through the sync chain and keep one cycle of history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/nibble_update_sched.sv
// Round-robin scheduler sharing one external 4-bit add/sub unit across the
// four nibbles of a 16-bit display number.
//
// state    | meaning
// ST_IDLE  | no operation in flight; picks next pending nibble
// ST_ISSUE | operands for nibble r_sel presented to the shared unit
// ST_WRITE | operands held; result written back at the clock edge
module nibble_update_sched
  import nibble_update_sched_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE  = 16'hABCD,
  parameter logic [3:0]  STEP        = 4'h1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_btn,
  input  logic [3:0]  i_sw,
  output logic [3:0]  o_alu_a,
  output logic [3:0]  o_alu_b,
  output logic        o_alu_ctrl,
  input  logic [3:0]  i_alu_s,
  output logic [15:0] o_num,
  output logic [3:0]  o_grant,
  output logic        o_busy,
  output logic        o_drop
);

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [1:0]      r_rr_ptr;
  logic [15:0]     r_num;
  logic [NNIB-1:0] r_pending;
  logic [NNIB-1:0] r_dir;
  logic [NNIB-1:0] r_grant;
  logic            r_busy;
  logic            r_drop;
  logic [3:0]      r_alu_a;
  logic            r_alu_ctrl;

  logic [NNIB-1:0] w_edge;
  logic [NNIB-1:0] w_clr;
  logic [NNIB-1:0] w_set;
  logic [1:0]      w_pick;

  for (genvar g = 0; g < NNIB; g++) begin : g_btn
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn[g]),
      .o_pulse (w_edge[g])
    );
  end

  // A nibble being written back frees its pending slot this cycle, so a
  // coincident edge on it is accepted rather than dropped.
  assign w_clr  = (r_state == ST_WRITE) ? (4'b0001 << r_sel) : 4'b0000;
  assign w_set  = w_edge & (~r_pending | w_clr);
  assign w_pick = rr_pick(r_pending, r_rr_ptr);

  // Request latch: accept edges, capture direction, flag dropped requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_dir     <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_dir     <= (r_dir & ~w_set) | (i_sw & w_set);
      r_drop    <= |(w_edge & r_pending & ~w_clr);
    end
  end

  // Scheduler FSM with registered unit operands and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= 2'd0;
      r_rr_ptr   <= 2'd0;
      r_num      <= INIT_VALUE;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_alu_a    <= 4'h0;
      r_alu_ctrl <= ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_sel      <= w_pick;
            r_grant    <= 4'b0001 << w_pick;
            r_busy     <= 1'b1;
            r_alu_a    <= r_num[{w_pick, 2'b00} +: 4];
            r_alu_ctrl <= r_dir[w_pick];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_num[{r_sel, 2'b00} +: 4] <= i_alu_s;
          r_rr_ptr   <= r_sel + 2'd1;
          r_grant    <= '0;
          r_busy     <= 1'b0;
          r_alu_a    <= 4'h0;
          r_alu_ctrl <= ADD;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_grant    <= '0;
          r_busy     <= 1'b0;
          r_alu_a    <= 4'h0;
          r_alu_ctrl <= ADD;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = STEP;
  assign o_alu_ctrl = r_alu_ctrl;
  assign o_num      = r_num;
  assign o_grant    = r_grant;
  assign o_busy     = r_busy;
  assign o_drop     = r_drop;

endmodule

// File: tb/tb_nibble_update_sched.sv
// Directed bench for nibble_update_sched with an external add/sub model.
module tb_nibble_update_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic [3:0]  sw;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_ctrl;
  logic [3:0]  alu_s;
  logic [15:0] num;
  logic [3:0]  grant;
  logic        busy;
  logic        drop;

  int n_checks = 0;
  int n_errors = 0;

  nibble_update_sched dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn      (btn),
    .i_sw       (sw),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_ctrl (alu_ctrl),
    .i_alu_s    (alu_s),
    .o_num      (num),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_drop     (drop)
  );

  // The shared unit lives outside the block.
  assign alu_s = alu_ctrl ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'h0;
    sw  = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  logic [3:0]  exp3   [11];
  logic [3:0]  exp_g  [16];
  logic [15:0] exp_n  [16];
  logic        exp_d  [9];
  int          gcnt;

  initial begin
    exp3 = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
    exp_g = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
              4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
    exp_n = '{16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD,
              16'hABCC, 16'hABCC, 16'hABCC, 16'hABDC, 16'hABDC, 16'hABDC,
              16'hAADC, 16'hAADC, 16'hAADC, 16'hBADC};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    btn = 4'h0;
    sw  = 4'h0;

    // Idle after reset.
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("idle_num",   32'(num),   32'hABCD);
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_busy",  32'(busy),  32'h0);
      chk("idle_alu_a", 32'(alu_a), 32'h0);
      chk("idle_drop",  32'(drop),  32'h0);
    end

    // Single increment of nibble 0.
    do_reset();
    sw[0]  = 1'b0;
    btn[0] = 1'b1;
    gcnt   = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (grant == 4'b0001) begin
        gcnt++;
        chk("inc0_ctrl",  32'(alu_ctrl), 32'h0);
        chk("inc0_alu_a", 32'(alu_a),    32'hD);
        chk("inc0_alu_b", 32'(alu_b),    32'h1);
      end
    end
    chk("inc0_num",        32'(num),   32'hABCE);
    chk("inc0_grant_len",  32'(gcnt),  32'd2);
    chk("inc0_busy_after", 32'(busy),  32'h0);
    chk("inc0_alu_a_idle", 32'(alu_a), 32'h0);
    btn[0] = 1'b0;
    repeat (4) tick();

    // Repeated decrements of nibble 3 through the 0 -> F wrap.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      sw[3]  = 1'b1;
      btn[3] = 1'b1;
      repeat (4) tick();
      btn[3] = 1'b0;
      repeat (8) tick();
      chk("dec3_nib3",   32'(num[15:12]), 32'(exp3[k]));
      chk("dec3_others", 32'(num[11:0]),  32'hBCD);
    end

    // All four at once: round-robin order and per-nibble direction.
    do_reset();
    sw  = 4'b0101;
    btn = 4'b1111;
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk($sformatf("all4_grant_t%0d", t), 32'(grant), 32'(exp_g[t]));
      chk($sformatf("all4_num_t%0d", t),   32'(num),   32'(exp_n[t]));
    end
    btn = 4'h0;
    repeat (4) tick();

    // Second edge on an already-pending nibble is dropped.
    do_reset();
    sw  = 4'b0000;
    btn = 4'b0011;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) btn = 4'b0001;
      if (t == 2) btn = 4'b0011;
      chk($sformatf("drop_t%0d", t), 32'(drop), 32'(exp_d[t]));
    end
    repeat (20) tick();
    chk("drop_num", 32'(num), 32'hABDE);
    btn = 4'h0;
    repeat (4) tick();

    // Reset during ISSUE abandons the nibble 2 update.
    do_reset();
    sw[2]  = 1'b0;
    btn[2] = 1'b1;
    repeat (4) tick();
    chk("rst_issue_grant", 32'(grant), 32'h4);
    chk("rst_issue_busy",  32'(busy),  32'h1);
    chk("rst_issue_alu_a", 32'(alu_a), 32'hB);
    rst = 1'b1;
    btn = 4'h0;
    tick();
    chk("rst_num",   32'(num),   32'hABCD);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("post_rst_busy", 32'(busy), 32'h0);
    end
    chk("post_rst_num", 32'(num), 32'hABCD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
